// File: rtl/ctl_paddles.sv
// Per-player paddle controller: debounced up/down buttons step each paddle
// once per frame tick, with hold-to-accelerate and saturation at both stops.
module ctl_paddles #(
    parameter int N_PLY      = 2,
    parameter int POS_W      = 10,
    parameter int LO         = 5,
    parameter int HI         = 595,
    parameter int INIT       = 300,
    parameter int SPEED      = 1,
    parameter int SPEED_FAST = 4,
    parameter int ACC_TICKS  = 16,
    parameter int DB_CYC     = 250000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [N_PLY-1:0]         btn_up,
    input  logic [N_PLY-1:0]         btn_dn,
    output logic [N_PLY*POS_W-1:0]   pos,
    output logic [N_PLY-1:0]         moving
);

    typedef enum logic [1:0] {
        IDLE,
        SLOW,
        FAST
    } state_t;

    localparam int NB     = 2 * N_PLY;
    localparam int DB_W   = $clog2(DB_CYC + 1);
    localparam int HOLD_W = $clog2(ACC_TICKS + 1);
    localparam int PW1    = POS_W + 1;

    localparam logic [POS_W:0]    LO_X   = PW1'(LO);
    localparam logic [POS_W:0]    HI_X   = PW1'(HI);
    localparam logic [POS_W:0]    SP_X   = PW1'(SPEED);
    localparam logic [POS_W:0]    SF_X   = PW1'(SPEED_FAST);
    localparam logic [POS_W-1:0]  INIT_P = POS_W'(INIT);
    localparam logic [DB_W-1:0]   DB_END = DB_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] ACC_H  = HOLD_W'(ACC_TICKS);

    // Buttons 0..N_PLY-1 are "up", N_PLY..2*N_PLY-1 are "down".
    logic [NB-1:0] raw;
    logic [NB-1:0] db;

    assign raw = {btn_dn, btn_up};

    function automatic logic [POS_W-1:0] step_pos(
        input logic [POS_W-1:0] cur,
        input logic             down,
        input logic             fast
    );
        logic [POS_W:0] amt;
        logic [POS_W:0] nx;
        amt = fast ? SF_X : SP_X;
        if (down) begin
            nx = {1'b0, cur} + amt;
            if (nx > HI_X) nx = HI_X;
        end else begin
            nx = {1'b0, cur} - amt;
            // Top bit set means the subtraction went below zero.
            if (nx[POS_W] || nx < LO_X) nx = LO_X;
        end
        return nx[POS_W-1:0];
    endfunction

    for (genvar b = 0; b < NB; b++) begin : g_db
        logic            s1;
        logic            s2;
        logic            q;
        logic [DB_W-1:0] cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                q   <= 1'b0;
                cnt <= '0;
            end else begin
                s1 <= raw[b];
                s2 <= s1;
                if (s2 == q) begin
                    cnt <= '0;
                end else if (cnt == DB_END) begin
                    q   <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign db[b] = q;
    end

    for (genvar c = 0; c < N_PLY; c++) begin : g_ch
        state_t            st;
        logic              dir_dn;
        logic [HOLD_W-1:0] hold;
        logic [POS_W-1:0]  p;
        logic              mv;
        logic              up_d;
        logic              dn_d;
        logic              any_d;

        assign up_d  = db[c] & ~db[N_PLY+c];
        assign dn_d  = db[N_PLY+c] & ~db[c];
        assign any_d = up_d | dn_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st     <= IDLE;
                dir_dn <= 1'b0;
                hold   <= '0;
                p      <= INIT_P;
                mv     <= 1'b0;
            end else if (tick) begin
                unique case (st)
                    IDLE: begin
                        if (any_d) begin
                            p      <= step_pos(p, dn_d, 1'b0);
                            dir_dn <= dn_d;
                            hold   <= HOLD_W'(1);
                            st     <= SLOW;
                            mv     <= 1'b1;
                        end
                    end
                    SLOW: begin
                        if (!any_d) begin
                            st   <= IDLE;
                            hold <= '0;
                            mv   <= 1'b0;
                        end else if (dn_d == dir_dn) begin
                            p    <= step_pos(p, dir_dn, 1'b0);
                            hold <= hold + 1'b1;
                            if (hold + 1'b1 == ACC_H) st <= FAST;
                        end else begin
                            p      <= step_pos(p, dn_d, 1'b0);
                            dir_dn <= dn_d;
                            hold   <= HOLD_W'(1);
                        end
                    end
                    FAST: begin
                        if (!any_d) begin
                            st   <= IDLE;
                            hold <= '0;
                            mv   <= 1'b0;
                        end else if (dn_d == dir_dn) begin
                            p <= step_pos(p, dir_dn, 1'b1);
                        end else begin
                            p      <= step_pos(p, dn_d, 1'b0);
                            dir_dn <= dn_d;
                            hold   <= HOLD_W'(1);
                            st     <= SLOW;
                        end
                    end
                    default: begin
                        st   <= IDLE;
                        hold <= '0;
                        mv   <= 1'b0;
                    end
                endcase
            end
        end

        assign pos[c*POS_W +: POS_W] = p;
        assign moving[c]             = mv;
    end

endmodule

// File: tb/tb_ctl_paddles.sv
// Bench for ctl_paddles: windowed debounce + per-tick motion model checked
// every cycle, plus directed scenarios with hand-computed positions.
module tb_ctl_paddles;

    localparam int DB   = 8;
    localparam int ACC  = 4;
    localparam int PW   = 10;
    localparam int LO   = 5;
    localparam int HI   = 595;
    localparam int INIT = 300;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick = 1'b0;
    logic [1:0]    btn_up = '0;
    logic [1:0]    btn_dn = '0;
    logic [2*PW-1:0] pos;
    logic [1:0]    moving;

    int n_cmp = 0;
    int n_bad = 0;

    int mpos[2];
    int mhold[2];
    int mdir[2];
    bit mdb[2][2];
    bit hist[2][2][DB+1];

    ctl_paddles #(
        .DB_CYC(DB),
        .ACC_TICKS(ACC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .btn_up(btn_up),
        .btn_dn(btn_dn),
        .pos(pos),
        .moving(moving)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mpos[c]  = INIT;
            mhold[c] = 0;
            mdir[c]  = 0;
            for (int b = 0; b < 2; b++) begin
                mdb[c][b] = 1'b0;
                for (int k = 0; k <= DB; k++) hist[c][b][k] = 1'b0;
            end
        end
    endtask

    // Motion uses the debounced state from before this edge; a button's
    // debounced value flips once the pin, seen two edges late, has disagreed
    // with it for DB consecutive samples.
    task automatic model_step();
        int d;
        int nx;
        bit pin;
        bit all_diff;
        if (tick) begin
            for (int c = 0; c < 2; c++) begin
                d = (mdb[c][0] && !mdb[c][1]) ? -1 :
                    (mdb[c][1] && !mdb[c][0]) ? 1 : 0;
                if (d == 0) begin
                    mhold[c] = 0;
                    mdir[c]  = 0;
                end else begin
                    if (d == mdir[c] && mhold[c] >= ACC) begin
                        nx = mpos[c] + 4 * d;
                    end else begin
                        nx = mpos[c] + d;
                        mhold[c] = (d == mdir[c]) ? mhold[c] + 1 : 1;
                        mdir[c]  = d;
                    end
                    mpos[c] = (nx < LO) ? LO : (nx > HI) ? HI : nx;
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            for (int b = 0; b < 2; b++) begin
                pin = (b == 1) ? btn_dn[c] : btn_up[c];
                all_diff = 1'b1;
                for (int k = 1; k <= DB; k++)
                    if (hist[c][b][k] == mdb[c][b]) all_diff = 1'b0;
                if (all_diff) mdb[c][b] = !mdb[c][b];
                for (int k = DB; k >= 1; k--) hist[c][b][k] = hist[c][b][k-1];
                hist[c][b][0] = pin;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        logic [2*PW-1:0] ep;
        logic [1:0]      em;
        ep = {PW'(mpos[1]), PW'(mpos[0])};
        em = {mhold[1] > 0, mhold[0] > 0};
        n_cmp++;
        if (pos !== ep || moving !== em) begin
            n_bad++;
            $display("FAIL model_cmp t=%0t got pos=%0d/%0d mv=%b want pos=%0d/%0d mv=%b",
                     $time, pos[PW-1:0], pos[2*PW-1:PW], moving,
                     mpos[0], mpos[1], em);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    int exp3[6] = '{299, 298, 297, 296, 292, 288};

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_pos0", int'(pos[PW-1:0]), 300);
        check("rst_pos1", int'(pos[2*PW-1:PW]), 300);
        check("rst_moving", int'(moving), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            btn_dn[0] = ((i / 3) % 2) == 1;
            tick = (i % 4) == 0;
        end
        @(posedge clk);
        #1 tick = 1'b0;
        check("bounce_pos0", int'(pos[PW-1:0]), 300);
        check("bounce_mv0", int'(moving[0]), 0);
        wait_cyc(10);
        do_tick();
        check("first_step_pos0", int'(pos[PW-1:0]), 301);
        check("first_step_mv0", int'(moving[0]), 1);
        do_tick();
        do_tick();
        check("dn_303", int'(pos[PW-1:0]), 303);
        btn_dn[0] = 1'b0;
        wait_cyc(12);
        do_tick();
        check("idle_pos0", int'(pos[PW-1:0]), 303);
        check("idle_mv0", int'(moving[0]), 0);

        btn_up[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_cyc(18);
            do_tick();
            check($sformatf("accel_pos1_%0d", i), int'(pos[2*PW-1:PW]), exp3[i]);
        end
        btn_up[1] = 1'b0;
        wait_cyc(18);
        do_tick();
        check("release_mv1", int'(moving[1]), 0);
        check("release_pos1", int'(pos[2*PW-1:PW]), 288);

        btn_up[0] = 1'b1;
        wait_cyc(12);
        repeat (77) do_tick();
        check("fast_up_7", int'(pos[PW-1:0]), 7);
        do_tick();
        check("clamp_lo", int'(pos[PW-1:0]), 5);
        do_tick();
        check("hold_lo", int'(pos[PW-1:0]), 5);
        check("hold_lo_mv", int'(moving[0]), 1);
        btn_up[0] = 1'b0;
        btn_dn[0] = 1'b1;
        wait_cyc(12);
        do_tick();
        check("rev_from_lo", int'(pos[PW-1:0]), 6);
        repeat (149) do_tick();
        check("fast_dn_593", int'(pos[PW-1:0]), 593);
        do_tick();
        check("clamp_hi", int'(pos[PW-1:0]), 595);
        do_tick();
        check("hold_hi", int'(pos[PW-1:0]), 595);

        btn_up[1] = 1'b1;
        btn_dn[1] = 1'b1;
        wait_cyc(12);
        repeat (3) do_tick();
        check("both_pos1", int'(pos[2*PW-1:PW]), 288);
        check("both_mv1", int'(moving[1]), 0);
        btn_dn[0] = 1'b0;
        btn_up[0] = 1'b1;
        wait_cyc(12);
        do_tick();
        check("rev_fast_slow", int'(pos[PW-1:0]), 594);
        check("rev_fast_mv", int'(moving[0]), 1);
        repeat (3) do_tick();
        check("rev_hold_591", int'(pos[PW-1:0]), 591);
        do_tick();
        check("rev_refast_587", int'(pos[PW-1:0]), 587);

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pos0", int'(pos[PW-1:0]), 300);
        check("mid_rst_pos1", int'(pos[2*PW-1:PW]), 300);
        check("mid_rst_mv", int'(moving), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (9) @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1;
        check("redb_early_pos0", int'(pos[PW-1:0]), 300);
        check("redb_early_mv0", int'(moving[0]), 0);
        @(posedge clk);
        #1 tick = 1'b0;
        check("redb_step_pos0", int'(pos[PW-1:0]), 299);
        check("redb_step_mv0", int'(moving[0]), 1);
        check("redb_pos1", int'(pos[2*PW-1:PW]), 300);

        wait_cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
